// File: rtl/w_stage_reg.sv
// Write-back pipeline register for the pipelined Y86-64 core, with bubble/stall
// control, a RUN/HALT freeze FSM and a saturating retired-instruction counter.
// Optional stall/bubble performance counters are compiled in with WB_PERF_EN.
module w_stage_reg #(
  parameter int DATA_W    = 64,
  parameter int REG_W     = 4,
  parameter int STAT_W    = 3,
  parameter int CNT_W     = 32,
  parameter int STAT_AOK  = 1,
  parameter int ICODE_NOP = 1,
  parameter int REG_NONE  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [3:0]        M_icode,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [REG_W-1:0]  M_dstE,
  input  logic [REG_W-1:0]  M_dstM,
  input  logic              m_Cnd,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [STAT_W-1:0] W_stat,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [REG_W-1:0]  W_dstE,
  output logic [REG_W-1:0]  W_dstM,
  output logic              W_Cnd,
  output logic              W_halted,
  output logic [CNT_W-1:0]  W_retired
`ifdef WB_PERF_EN
  ,
  output logic [CNT_W-1:0]  W_stall_cnt,
  output logic [CNT_W-1:0]  W_bubble_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state_q, state_d;
  logic   load_en;
  logic   bubble_en;
  logic   stall_en;

  // Stall outranks bubble; HALT ignores every control except rst.
  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    bubble_en = 1'b0;
    stall_en  = 1'b0;
    case (state_q)
      RUN: begin
        if (W_stall) begin
          stall_en = 1'b1;
        end else if (W_bubble) begin
          bubble_en = 1'b1;
        end else begin
          load_en = 1'b1;
          if (m_stat != STAT_W'(STAT_AOK)) state_d = HALT;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign W_halted = (state_q == HALT);

  always_ff @(posedge clk) begin
    if (rst || bubble_en) begin
      W_stat  <= STAT_W'(STAT_AOK);
      W_icode <= 4'(ICODE_NOP);
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= REG_W'(REG_NONE);
      W_dstM  <= REG_W'(REG_NONE);
      W_Cnd   <= 1'b0;
    end else if (load_en) begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
      W_Cnd   <= m_Cnd;
    end
  end

  // Saturation is tested before the increment so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst)                           W_retired <= '0;
    else if (load_en && ~&W_retired)   W_retired <= W_retired + CNT_W'(1);
  end

`ifdef WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                            W_stall_cnt <= '0;
    else if (stall_en && ~&W_stall_cnt) W_stall_cnt <= W_stall_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                              W_bubble_cnt <= '0;
    else if (bubble_en && ~&W_bubble_cnt) W_bubble_cnt <= W_bubble_cnt + CNT_W'(1);
  end
`else
  logic unused_stall;
  assign unused_stall = stall_en;
`endif

endmodule

// File: tb/tb_w_stage_reg.sv
// Scoreboard bench for w_stage_reg: a behavioural model predicts each edge,
// a monitor compares after every edge. A CNT_W=3 copy exercises saturation.
module tb_w_stage_reg;

  logic        clk = 1'b0;
  logic        rst, m_Cnd, W_stall, W_bubble;
  logic [2:0]  m_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, m_valM;

  logic [2:0]  W_stat,  s_stat;
  logic [3:0]  W_icode, s_icode, W_dstE, s_dstE, W_dstM, s_dstM;
  logic [63:0] W_valE,  s_valE,  W_valM, s_valM;
  logic        W_Cnd, s_Cnd, W_halted, s_halted;
  logic [31:0] W_retired;
  logic [2:0]  s_retired;
`ifdef WB_PERF_EN
  logic [31:0] W_stall_cnt, W_bubble_cnt;
  logic [2:0]  s_stall_cnt, s_bubble_cnt;
`endif

  w_stage_reg dut (
    .clk(clk), .rst(rst), .m_stat(m_stat), .M_icode(M_icode), .M_valE(M_valE),
    .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM), .m_Cnd(m_Cnd),
    .W_stall(W_stall), .W_bubble(W_bubble), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_Cnd(W_Cnd), .W_halted(W_halted), .W_retired(W_retired)
`ifdef WB_PERF_EN
    , .W_stall_cnt(W_stall_cnt), .W_bubble_cnt(W_bubble_cnt)
`endif
  );

  w_stage_reg #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .m_stat(m_stat), .M_icode(M_icode), .M_valE(M_valE),
    .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM), .m_Cnd(m_Cnd),
    .W_stall(W_stall), .W_bubble(W_bubble), .W_stat(s_stat), .W_icode(s_icode),
    .W_valE(s_valE), .W_valM(s_valM), .W_dstE(s_dstE), .W_dstM(s_dstM),
    .W_Cnd(s_Cnd), .W_halted(s_halted), .W_retired(s_retired)
`ifdef WB_PERF_EN
    , .W_stall_cnt(s_stall_cnt), .W_bubble_cnt(s_bubble_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        cnd;
    logic        halted;
    logic [31:0] retired;
    logic [2:0]  retired_small;
    logic [31:0] stall_n;
    logic [31:0] bubble_n;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // behavioural model: architectural W contents plus unbounded event counts
  exp_t    mdl;
  longint  retired_total, stall_total, bubble_total;

  function automatic logic [31:0] sat(input longint v, input longint max);
    return (v > max) ? 32'(max) : 32'(v);
  endfunction

  task automatic model_reset_values();
    mdl.stat = 3'd1; mdl.icode = 4'd1; mdl.val_e = '0; mdl.val_m = '0;
    mdl.dst_e = 4'd15; mdl.dst_m = 4'd15; mdl.cnd = 1'b0;
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [2:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm, input logic c);
    @(negedge clk);
    rst = r; W_stall = s; W_bubble = b; m_stat = st; M_icode = ic;
    M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm; m_Cnd = c;
    if (r) begin
      model_reset_values();
      mdl.halted = 1'b0;
      retired_total = 0; stall_total = 0; bubble_total = 0;
    end else if (!mdl.halted) begin
      if (s) begin
        stall_total++;
      end else if (b) begin
        model_reset_values();
        bubble_total++;
      end else begin
        mdl.stat = st; mdl.icode = ic; mdl.val_e = ve; mdl.val_m = vm;
        mdl.dst_e = de; mdl.dst_m = dm; mdl.cnd = c;
        retired_total++;
        if (st != 3'd1) mdl.halted = 1'b1;
      end
    end
    mdl.retired       = sat(retired_total, 64'hFFFF_FFFF);
    mdl.retired_small = 3'(sat(retired_total, 7));
    mdl.stall_n       = sat(stall_total, 64'hFFFF_FFFF);
    mdl.bubble_n      = sat(bubble_total, 64'hFFFF_FFFF);
    exp_q.push_back(EXP_W'(mdl));
  endtask

  task automatic load(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve);
    drive(1'b0, 1'b0, 1'b0, st, ic, ve, 64'h0, 4'd3, 4'd15, 1'b1);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: one expected entry per edge, compared 1 time unit later
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("W_stat",    64'(W_stat),    64'(e.stat));
      chk("W_icode",   64'(W_icode),   64'(e.icode));
      chk("W_valE",    W_valE,         e.val_e);
      chk("W_valM",    W_valM,         e.val_m);
      chk("W_dstE",    64'(W_dstE),    64'(e.dst_e));
      chk("W_dstM",    64'(W_dstM),    64'(e.dst_m));
      chk("W_Cnd",     64'(W_Cnd),     64'(e.cnd));
      chk("W_halted",  64'(W_halted),  64'(e.halted));
      chk("W_retired", 64'(W_retired), 64'(e.retired));
      chk("small_retired", 64'(s_retired), 64'(e.retired_small));
      chk("small_halted",  64'(s_halted),  64'(e.halted));
`ifdef WB_PERF_EN
      chk("W_stall_cnt",  64'(W_stall_cnt),  64'(e.stall_n));
      chk("W_bubble_cnt", 64'(W_bubble_cnt), 64'(e.bubble_n));
      chk("small_stall_cnt", 64'(s_stall_cnt), 64'(sat(64'(e.stall_n), 7)));
`endif
    end
  end

  initial begin
    int wait_cycles;
    mdl = '0;
    retired_total = 0; stall_total = 0; bubble_total = 0;
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; m_stat = 3'd1; M_icode = 4'd0;
    M_valE = '0; m_valM = '0; M_dstE = '0; M_dstM = '0; m_Cnd = 1'b0;

    // reset then idle
    drive(1'b1, 1'b0, 1'b0, 3'd1, 4'd6, 64'h55, 64'h66, 4'd2, 4'd4, 1'b1);
    // normal load
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'd6, 64'h10, 64'h0, 4'd3, 4'd15, 1'b1);
    // stall beats bubble, then a plain bubble
    load(3'd1, 4'd6, 64'hAB);
    drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd3, 64'hCD, 64'h1, 4'd5, 4'd6, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd5, 64'hEF, 64'h2, 4'd7, 4'd8, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 3'd1, 4'd5, 64'h99, 64'h3, 4'd1, 4'd2, 1'b1);
    // bubble with exception status never halts
    drive(1'b0, 1'b0, 1'b1, 3'd4, 4'd9, 64'h77, 64'h4, 4'd1, 4'd2, 1'b1);
    // halt on exception retirement, then frozen
    load(3'd2, 4'd0, 64'h0);
    for (int i = 0; i < 5; i++) load(3'd1, 4'd6, 64'(i + 100));
    drive(1'b0, 1'b0, 1'b1, 3'd1, 4'd6, 64'h1, 64'h1, 4'd1, 4'd1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 4'd6, 64'h1, 64'h1, 4'd1, 4'd1, 1'b0);
    // saturation of the 3-bit copy
    for (int i = 0; i < 9; i++) load(3'd1, 4'd6, 64'(i));
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b0, 3'd1, 4'd6, 64'h5, 64'h5, 4'd1, 4'd1, 1'b0);

    // randomized traffic with occasional exceptions and resets
    for (int i = 0; i < 600; i++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), st, 4'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom), 4'($urandom), 1'($urandom));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
